// File: rtl/sdram_arbiter_pkg.sv
// Shared constants for the three-way SDRAM request arbiter.
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - requester indices used for grant and ack bit positions
//   - run counter width
package sdram_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] REQ_VIDEO  = 2'd0;
    localparam logic [1:0] REQ_CPU    = 2'd1;
    localparam logic [1:0] REQ_AUX    = 2'd2;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    localparam int RUN_BITS = 4;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the SDRAM controller.
//
// Handshake:
//   Requester side: req[i] is a valid that stays high, with we/addr/wdata/be
//   stable, until ack[i] pulses for one cycle. There is no separate ready; the
//   ack pulse is the completion. rdata is valid only in the ack cycle.
//   Controller side: ctl_req is a valid held high with all ctl_* fields stable
//   until the controller returns a one-cycle ctl_ack, with ctl_rdata valid in
//   that same cycle.
//
// Modports:
//   slave  - arbiter view (consumes requests, drives controller command)
//   master - environment view (requesters + controller model)
interface sdram_arbiter_if #(
    parameter int ADDR_BITS = 24
);
    logic [2:0]           req;
    logic [2:0]           we;
    logic [ADDR_BITS-1:0] addr_v, addr_c, addr_a;
    logic [31:0]          wdata_v, wdata_c, wdata_a;
    logic [3:0]           be_v, be_c, be_a;
    logic [2:0]           ack;
    logic [31:0]          rdata;
    logic [1:0]           grant;
    logic                 ctl_req;
    logic                 ctl_we;
    logic [ADDR_BITS-1:0] ctl_addr;
    logic [31:0]          ctl_wdata;
    logic [3:0]           ctl_be;
    logic                 ctl_ack;
    logic [31:0]          ctl_rdata;

    modport slave (
        input  req, we, addr_v, addr_c, addr_a, wdata_v, wdata_c, wdata_a,
               be_v, be_c, be_a, ctl_ack, ctl_rdata,
        output ack, rdata, grant, ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_be
    );

    modport master (
        output req, we, addr_v, addr_c, addr_a, wdata_v, wdata_c, wdata_a,
               be_v, be_c, be_a, ctl_ack, ctl_rdata,
        input  ack, rdata, grant, ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_be
    );

endinterface

// File: rtl/sdram_arbiter_pick.sv
// Combinational winner selection for the SDRAM arbiter.
// Ports:
//   req_i     - request bits [0]=video [1]=cpu [2]=aux
//   run_cnt_i - consecutive video grants taken while cpu/aux were waiting
//   rr_i      - 0: cpu wins a cpu/aux tie, 1: aux wins
//   winner_o  - winning requester index (GRANT_NONE when nothing requests)
//   valid_o   - at least one request present
module sdram_arbiter_pick
    import sdram_arbiter_pkg::*;
#(
    parameter int VIDEO_MAX_RUN = 4
) (
    input  logic [2:0]          req_i,
    input  logic [RUN_BITS-1:0] run_cnt_i,
    input  logic                rr_i,
    output logic [1:0]          winner_o,
    output logic                valid_o
);

    logic video_blocked;

    // Video yields only once its run is used up and someone else is waiting.
    assign video_blocked = (run_cnt_i == RUN_BITS'(VIDEO_MAX_RUN)) && (req_i[1] || req_i[2]);
    assign valid_o       = |req_i;

    always_comb begin
        winner_o = GRANT_NONE;
        if (req_i[0] && !video_blocked) begin
            winner_o = REQ_VIDEO;
        end else if (req_i[1] && req_i[2]) begin
            winner_o = rr_i ? REQ_AUX : REQ_CPU;
        end else if (req_i[1]) begin
            winner_o = REQ_CPU;
        end else if (req_i[2]) begin
            winner_o = REQ_AUX;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-way arbiter sharing the SDRAM controller request port between the
// video fetcher (fixed priority, bounded run), the CPU and an aux DMA master
// (round-robin between the latter two).
// Ports:
//   clk_sdram   - controller clock
//   rst         - synchronous active-high reset
//   bus         - requester + controller bundle (slave modport)
//   state_dbg_o - current FSM state for observation
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 24,
    parameter int VIDEO_MAX_RUN = 4    // 1..15
) (
    input  logic               clk_sdram,
    input  logic               rst,
    sdram_arbiter_if.slave     bus,
    output logic [1:0]         state_dbg_o
);

    logic [1:0]           state_q, state_d;
    logic                 ctl_req_q, ctl_req_d;
    logic                 ctl_we_q, ctl_we_d;
    logic [ADDR_BITS-1:0] ctl_addr_q, ctl_addr_d;
    logic [31:0]          ctl_wdata_q, ctl_wdata_d;
    logic [3:0]           ctl_be_q, ctl_be_d;
    logic [2:0]           ack_q, ack_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           grant_q, grant_d;
    logic [RUN_BITS-1:0]  run_cnt_q, run_cnt_d;
    logic                 rr_q, rr_d;

    logic [1:0]           winner;
    logic                 winner_valid;

    sdram_arbiter_pick #(.VIDEO_MAX_RUN(VIDEO_MAX_RUN)) u_pick (
        .req_i     (bus.req),
        .run_cnt_i (run_cnt_q),
        .rr_i      (rr_q),
        .winner_o  (winner),
        .valid_o   (winner_valid)
    );

    always_comb begin
        state_d     = state_q;
        ctl_req_d   = ctl_req_q;
        ctl_we_d    = ctl_we_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_wdata_d = ctl_wdata_q;
        ctl_be_d    = ctl_be_q;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        grant_d     = grant_q;
        run_cnt_d   = run_cnt_q;
        rr_d        = rr_q;

        case (state_q)
            ST_IDLE: begin
                if (winner_valid) begin
                    state_d   = ST_BUSY;
                    ctl_req_d = 1'b1;
                    grant_d   = winner;
                    ctl_we_d  = bus.we[winner];
                    case (winner)
                        REQ_VIDEO: begin
                            ctl_addr_d  = bus.addr_v;
                            ctl_wdata_d = bus.wdata_v;
                            ctl_be_d    = bus.be_v;
                        end
                        REQ_CPU: begin
                            ctl_addr_d  = bus.addr_c;
                            ctl_wdata_d = bus.wdata_c;
                            ctl_be_d    = bus.be_c;
                        end
                        default: begin
                            ctl_addr_d  = bus.addr_a;
                            ctl_wdata_d = bus.wdata_a;
                            ctl_be_d    = bus.be_a;
                        end
                    endcase
                    if (winner == REQ_VIDEO) begin
                        // Only runs taken while others wait count toward the limit.
                        if (bus.req[1] || bus.req[2]) begin
                            if (run_cnt_q != RUN_BITS'(VIDEO_MAX_RUN)) begin
                                run_cnt_d = run_cnt_q + RUN_BITS'(1);
                            end
                        end else begin
                            run_cnt_d = '0;
                        end
                    end else begin
                        run_cnt_d = '0;
                        // Remember who went last so the other wins the next tie.
                        rr_d      = (winner == REQ_CPU);
                    end
                end
            end
            ST_BUSY: begin
                if (bus.ctl_ack) begin
                    state_d   = ST_DONE;
                    ctl_req_d = 1'b0;
                    rdata_d   = bus.ctl_rdata;
                    ack_d     = 3'b001 << grant_q;
                end
            end
            ST_DONE: begin
                // No arbitration here: gives the acked requester a cycle to drop req.
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_sdram) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ctl_req_q   <= 1'b0;
            ctl_we_q    <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_wdata_q <= '0;
            ctl_be_q    <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            grant_q     <= GRANT_NONE;
            run_cnt_q   <= '0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctl_req_q   <= ctl_req_d;
            ctl_we_q    <= ctl_we_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_wdata_q <= ctl_wdata_d;
            ctl_be_q    <= ctl_be_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            grant_q     <= grant_d;
            run_cnt_q   <= run_cnt_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.ctl_req   = ctl_req_q;
    assign bus.ctl_we    = ctl_we_q;
    assign bus.ctl_addr  = ctl_addr_q;
    assign bus.ctl_wdata = ctl_wdata_q;
    assign bus.ctl_be    = ctl_be_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.grant     = grant_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: table of vectors for the standalone winner picker,
// then hand-written multi-cycle sequences against the full arbiter.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int AB = 24;

    // ---------------- clock / reset ----------------
    logic clk_sdram = 1'b0;
    logic rst = 1'b1;
    always #5 clk_sdram = ~clk_sdram;

    sdram_arbiter_if #(.ADDR_BITS(AB)) bus ();
    logic [1:0] state_dbg;

    sdram_arbiter #(.ADDR_BITS(AB), .VIDEO_MAX_RUN(4)) dut (
        .clk_sdram   (clk_sdram),
        .rst         (rst),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // standalone picker
    logic [2:0] p_req;
    logic [3:0] p_cnt;
    logic       p_rr;
    logic [1:0] p_win;
    logic       p_valid;

    sdram_arbiter_pick #(.VIDEO_MAX_RUN(4)) u_pick (
        .req_i     (p_req),
        .run_cnt_i (p_cnt),
        .rr_i      (p_rr),
        .winner_o  (p_win),
        .valid_o   (p_valid)
    );

    typedef struct {
        logic [2:0] req;
        logic [3:0] cnt;
        logic       rr;
        logic [1:0] exp_win;
        logic       exp_valid;
    } pick_vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sdram);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req = '0; bus.we = '0;
        bus.addr_v = '0; bus.addr_c = '0; bus.addr_a = '0;
        bus.wdata_v = '0; bus.wdata_c = '0; bus.wdata_a = '0;
        bus.be_v = '0; bus.be_c = '0; bus.be_a = '0;
        bus.ctl_ack = 1'b0; bus.ctl_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a command, check its owner, ack it after lat cycles.
    task automatic serve(input logic [1:0] exp_grant, input int lat, input string tag);
        int waited;
        logic [2:0] exp_ack;
        waited = 0;
        while (bus.ctl_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " ctl_req"}, 64'(bus.ctl_req), 64'd1);
        check({tag, " grant"}, 64'(bus.grant), 64'(exp_grant));
        repeat (lat) tick();
        bus.ctl_rdata = 32'h1234_0000 + 32'(lat);
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        exp_ack = 3'b001 << exp_grant;
        check({tag, " ack"}, 64'(bus.ack), 64'(exp_ack));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pick_vec_t pv[13];
        logic [1:0] rr_exp[4];
        logic [1:0] vc_exp[10];

        pv[0]  = '{3'b000, 4'd0, 1'b0, 2'd3, 1'b0};
        pv[1]  = '{3'b001, 4'd0, 1'b0, 2'd0, 1'b1};
        pv[2]  = '{3'b011, 4'd3, 1'b0, 2'd0, 1'b1};
        pv[3]  = '{3'b011, 4'd4, 1'b0, 2'd1, 1'b1};
        pv[4]  = '{3'b101, 4'd4, 1'b0, 2'd2, 1'b1};
        pv[5]  = '{3'b111, 4'd4, 1'b0, 2'd1, 1'b1};
        pv[6]  = '{3'b111, 4'd4, 1'b1, 2'd2, 1'b1};
        pv[7]  = '{3'b110, 4'd0, 1'b0, 2'd1, 1'b1};
        pv[8]  = '{3'b110, 4'd0, 1'b1, 2'd2, 1'b1};
        pv[9]  = '{3'b010, 4'd0, 1'b1, 2'd1, 1'b1};
        pv[10] = '{3'b100, 4'd0, 1'b0, 2'd2, 1'b1};
        pv[11] = '{3'b001, 4'd4, 1'b0, 2'd0, 1'b1};
        pv[12] = '{3'b111, 4'd2, 1'b1, 2'd0, 1'b1};

        rr_exp = '{2'd1, 2'd2, 2'd1, 2'd2};
        vc_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

        // picker table
        for (int i = 0; i < 13; i++) begin
            p_req = pv[i].req;
            p_cnt = pv[i].cnt;
            p_rr  = pv[i].rr;
            #1;
            check($sformatf("pick[%0d] winner", i), 64'(p_win), 64'(pv[i].exp_win));
            check($sformatf("pick[%0d] valid", i), 64'(p_valid), 64'(pv[i].exp_valid));
        end

        // reset values
        do_reset();
        check("rst state", 64'(state_dbg), 64'(ST_IDLE));
        check("rst ctl_req", 64'(bus.ctl_req), 64'd0);
        check("rst ctl_we", 64'(bus.ctl_we), 64'd0);
        check("rst ctl_addr", 64'(bus.ctl_addr), 64'd0);
        check("rst ctl_wdata", 64'(bus.ctl_wdata), 64'd0);
        check("rst ctl_be", 64'(bus.ctl_be), 64'd0);
        check("rst ack", 64'(bus.ack), 64'd0);
        check("rst rdata", 64'(bus.rdata), 64'd0);
        check("rst grant", 64'(bus.grant), 64'd3);

        // single CPU read, controller acks 5 cycles after ctl_req
        bus.addr_c = 24'h000123;
        bus.req = 3'b010;
        tick();
        check("rd ctl_req", 64'(bus.ctl_req), 64'd1);
        check("rd ctl_addr", 64'(bus.ctl_addr), 64'h000123);
        check("rd ctl_we", 64'(bus.ctl_we), 64'd0);
        check("rd grant", 64'(bus.grant), 64'd1);
        check("rd state", 64'(state_dbg), 64'(ST_BUSY));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rd wait%0d ack", i), 64'(bus.ack), 64'd0);
            check($sformatf("rd wait%0d ctl_req", i), 64'(bus.ctl_req), 64'd1);
        end
        bus.ctl_rdata = 32'hC01DCAFE;
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        bus.ctl_rdata = 32'h0;
        check("rd ack", 64'(bus.ack), 64'b010);
        check("rd rdata", 64'(bus.rdata), 64'hC01DCAFE);
        check("rd done state", 64'(state_dbg), 64'(ST_DONE));
        check("rd done ctl_req", 64'(bus.ctl_req), 64'd0);
        bus.req = 3'b000;
        tick();
        check("rd idle ack", 64'(bus.ack), 64'd0);
        check("rd idle grant", 64'(bus.grant), 64'd3);
        check("rd idle state", 64'(state_dbg), 64'(ST_IDLE));

        // CPU + aux continuous: alternate, CPU first; latency 0 covers ack in first BUSY cycle
        do_reset();
        bus.req = 3'b110;
        for (int i = 0; i < 4; i++) serve(rr_exp[i], i, $sformatf("rr%0d", i));

        // video + CPU continuous: bounded video run
        do_reset();
        bus.req = 3'b011;
        for (int i = 0; i < 10; i++) serve(vc_exp[i], 1, $sformatf("vc%0d", i));

        // aux write, fields held while inputs change
        do_reset();
        bus.addr_a = 24'h0ABCDE;
        bus.wdata_a = 32'h600DBABE;
        bus.be_a = 4'b0011;
        bus.we = 3'b100;
        bus.req = 3'b100;
        tick();
        check("wr grant", 64'(bus.grant), 64'd2);
        check("wr ctl_we", 64'(bus.ctl_we), 64'd1);
        check("wr ctl_be", 64'(bus.ctl_be), 64'b0011);
        check("wr ctl_wdata", 64'(bus.ctl_wdata), 64'h600DBABE);
        check("wr ctl_addr", 64'(bus.ctl_addr), 64'h0ABCDE);
        bus.wdata_a = 32'hDEADBEEF;
        bus.be_a = 4'hF;
        bus.we = 3'b000;
        bus.req = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wr hold%0d ctl_we", i), 64'(bus.ctl_we), 64'd1);
            check($sformatf("wr hold%0d ctl_be", i), 64'(bus.ctl_be), 64'b0011);
            check($sformatf("wr hold%0d ctl_wdata", i), 64'(bus.ctl_wdata), 64'h600DBABE);
            check($sformatf("wr hold%0d grant", i), 64'(bus.grant), 64'd2);
            check($sformatf("wr hold%0d ctl_req", i), 64'(bus.ctl_req), 64'd1);
        end
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        check("wr ack", 64'(bus.ack), 64'b100);
        bus.req = 3'b010;
        tick();
        check("wr done->idle ctl_req", 64'(bus.ctl_req), 64'd0);
        check("wr done->idle grant", 64'(bus.grant), 64'd3);
        check("wr done->idle ack", 64'(bus.ack), 64'd0);
        tick();
        check("wr next ctl_req", 64'(bus.ctl_req), 64'd1);
        check("wr next grant", 64'(bus.grant), 64'd1);
        check("wr next ctl_we", 64'(bus.ctl_we), 64'd0);
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        check("wr next ack", 64'(bus.ack), 64'b010);
        bus.req = 3'b000;

        // reset two cycles into BUSY
        do_reset();
        bus.req = 3'b010;
        tick();
        check("mrst busy", 64'(state_dbg), 64'(ST_BUSY));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst ctl_req", 64'(bus.ctl_req), 64'd0);
        check("mrst grant", 64'(bus.grant), 64'd3);
        check("mrst ack", 64'(bus.ack), 64'd0);
        check("mrst state", 64'(state_dbg), 64'(ST_IDLE));
        tick();
        check("mrst regrant ctl_req", 64'(bus.ctl_req), 64'd1);
        check("mrst regrant grant", 64'(bus.grant), 64'd1);
        check("mrst regrant ack", 64'(bus.ack), 64'd0);
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        check("mrst final ack", 64'(bus.ack), 64'b010);
        bus.req = 3'b000;

        // spurious ctl_ack while IDLE
        do_reset();
        bus.ctl_ack = 1'b1;
        tick();
        bus.ctl_ack = 1'b0;
        check("spur state", 64'(state_dbg), 64'(ST_IDLE));
        check("spur ack", 64'(bus.ack), 64'd0);
        check("spur ctl_req", 64'(bus.ctl_req), 64'd0);
        check("spur grant", 64'(bus.grant), 64'd3);
        tick();
        check("spur ack later", 64'(bus.ack), 64'd0);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
